// File: rtl/wb_interconnect_n.sv
// wb_interconnect_n: single-master to NPERI-peripheral Wishbone interconnect.
// Decodes the peripheral index from the upper address bits, locks the selection
// for the whole transaction, and answers unmapped addresses and stalled
// peripherals with a bus error.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   m_stb/m_we/m_adr   master request (held stable until m_ack or m_err)
//   m_dat_c, m_dat_p   master write data in, read data out
//   m_ack, m_err       normal completion, error termination
//   p_stb              one-hot peripheral strobes
//   p_we/p_adr/p_dat_c broadcast write enable, low address bits, write data
//   p_dat_p, p_ack     per-peripheral read data slices and acknowledges
module wb_interconnect_n #(
    parameter int NPERI          = 4,
    parameter int PERI_ADR_WIDTH = 4,
    parameter int ADR_WIDTH      = 8,
    parameter int DAT_WIDTH      = 32,
    parameter int TIMEOUT        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_stb,
    input  logic                       m_we,
    input  logic [ADR_WIDTH-1:0]       m_adr,
    input  logic [DAT_WIDTH-1:0]       m_dat_c,
    output logic [DAT_WIDTH-1:0]       m_dat_p,
    output logic                       m_ack,
    output logic                       m_err,
    output logic [NPERI-1:0]           p_stb,
    output logic                       p_we,
    output logic [PERI_ADR_WIDTH-1:0]  p_adr,
    output logic [DAT_WIDTH-1:0]       p_dat_c,
    input  logic [NPERI*DAT_WIDTH-1:0] p_dat_p,
    input  logic [NPERI-1:0]           p_ack
);

    localparam int IDXW = ADR_WIDTH - PERI_ADR_WIDTH;
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [IDXW-1:0]      sel_q;
    logic [IDXW-1:0]      sel_d;
    logic [IDXW-1:0]      idx;
    logic [IDXW-1:0]      sel;
    logic [TW-1:0]        tmo_cnt;
    logic [TW-1:0]        tmo_d;
    logic                 valid;
    logic                 tmo_hit;
    logic                 stb_on;
    logic                 ack_sel;
    logic                 ack_o;
    logic                 err_o;
    logic [DAT_WIDTH-1:0] dat_sel;
    logic [NPERI-1:0]     stb_vec;

    assign p_we    = m_we;
    assign p_adr   = m_adr[PERI_ADR_WIDTH-1:0];
    assign p_dat_c = m_dat_c;

    assign idx     = m_adr[ADR_WIDTH-1:PERI_ADR_WIDTH];
    assign valid   = int'(idx) < NPERI;
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT));

    // The selection is live-decoded only while idle; once a transaction
    // stalls, the captured index is used so address changes cannot reroute.
    assign sel = (state == BUSY) ? sel_q : idx;

    always_comb begin : peri_mux
        ack_sel = 1'b0;
        dat_sel = '0;
        for (int i = 0; i < NPERI; i++) begin
            if (int'(sel) == i) begin
                ack_sel = p_ack[i];
                dat_sel = p_dat_p[i*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state;
        sel_d   = sel_q;
        tmo_d   = tmo_cnt;
        stb_on  = 1'b0;
        ack_o   = 1'b0;
        err_o   = 1'b0;
        unique case (state)
            IDLE: begin
                tmo_d = '0;
                if (m_stb) begin
                    if (!valid) begin
                        state_d = ERR;
                    end else begin
                        stb_on = 1'b1;
                        ack_o  = ack_sel;
                        if (!ack_sel) begin
                            state_d = BUSY;
                            sel_d   = idx;
                            tmo_d   = TW'(1);
                        end
                    end
                end
            end
            BUSY: begin
                if (!m_stb) begin
                    // Master abort: drop the strobe silently.
                    state_d = IDLE;
                    tmo_d   = '0;
                end else if (ack_sel) begin
                    // An ack on the timeout cycle still completes normally.
                    stb_on  = 1'b1;
                    ack_o   = 1'b1;
                    state_d = IDLE;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    err_o   = 1'b1;
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    stb_on = 1'b1;
                    tmo_d  = tmo_cnt + TW'(1);
                end
            end
            ERR: begin
                err_o   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin : stb_decode
        stb_vec = '0;
        for (int i = 0; i < NPERI; i++) begin
            if (stb_on && int'(sel) == i) begin
                stb_vec[i] = 1'b1;
            end
        end
    end

    // Outputs are gated by rst_n so a reset pulse kills the strobe and any
    // response at once, even while the master still holds its request.
    assign p_stb   = rst_n ? stb_vec : '0;
    assign m_ack   = rst_n & ack_o;
    assign m_err   = rst_n & err_o;
    assign m_dat_p = m_ack ? dat_sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_d;
            sel_q   <= sel_d;
            tmo_cnt <= tmo_d;
        end
    end

endmodule

// File: tb/tb_wb_interconnect_n.sv
// tb_wb_interconnect_n: scoreboard bench for wb_interconnect_n.
// A second instance with TIMEOUT=0 shares all inputs.
module tb_wb_interconnect_n;

    localparam int NP = 4;
    localparam int AW = 8;
    localparam int PW = 4;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           m_stb = 1'b0;
    logic           m_we = 1'b0;
    logic [AW-1:0]  m_adr = '0;
    logic [DW-1:0]  m_dat_c = '0;
    logic [NP*DW-1:0] p_dat_p = '0;
    logic [NP-1:0]  p_ack = '0;

    logic [DW-1:0]  m_dat_p;
    logic           m_ack;
    logic           m_err;
    logic [NP-1:0]  p_stb;
    logic           p_we;
    logic [PW-1:0]  p_adr;
    logic [DW-1:0]  p_dat_c;

    logic [DW-1:0]  nt_dat_p;
    logic           nt_ack;
    logic           nt_err;
    logic [NP-1:0]  nt_stb;
    logic           nt_we;
    logic [PW-1:0]  nt_adr;
    logic [DW-1:0]  nt_dat_c;

    typedef struct {
        logic          err;
        logic [DW-1:0] dat;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_interconnect_n #(
        .NPERI(NP), .PERI_ADR_WIDTH(PW), .ADR_WIDTH(AW),
        .DAT_WIDTH(DW), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_c(m_dat_c), .m_dat_p(m_dat_p),
        .m_ack(m_ack), .m_err(m_err), .p_stb(p_stb), .p_we(p_we),
        .p_adr(p_adr), .p_dat_c(p_dat_c), .p_dat_p(p_dat_p),
        .p_ack(p_ack)
    );

    wb_interconnect_n #(
        .NPERI(NP), .PERI_ADR_WIDTH(PW), .ADR_WIDTH(AW),
        .DAT_WIDTH(DW), .TIMEOUT(0)
    ) u_nt (
        .clk(clk), .rst_n(rst_n), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_c(m_dat_c), .m_dat_p(nt_dat_p),
        .m_ack(nt_ack), .m_err(nt_err), .p_stb(nt_stb), .p_we(nt_we),
        .p_adr(nt_adr), .p_dat_c(nt_dat_c), .p_dat_p(p_dat_p),
        .p_ack(p_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for m_ack or m_err; returns at the negedge where it appeared.
    task automatic wait_resp(input int budget, output logic got,
                             output logic err, output logic [DW-1:0] dat,
                             output int lat);
        got = 1'b0;
        err = 1'b0;
        dat = '0;
        lat = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_ack || m_err) begin
                got = 1'b1;
                err = m_err;
                dat = m_dat_p;
                lat = c;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        step();
        @(negedge clk);
        n_tests++;
        if (p_stb !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_stb: p_stb=%b want 0000", p_stb);
        end
        n_tests++;
        if ({m_ack, m_err, m_dat_p} !== {2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_resp: ack=%b err=%b dat=%h want 0 0 0",
                     m_ack, m_err, m_dat_p);
        end
        step();
        rst_n = 1'b1;
        p_dat_p = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'hA0A0A0A0};
    endtask

    task automatic test_zero_wait();
        logic got, err;
        logic [DW-1:0] dat;
        int lat;
        exp_t e;
        step();
        m_adr   = 8'h23;
        m_we    = 1'b1;
        m_dat_c = 32'hCAFEF00D;
        p_ack   = 4'b0100;
        m_stb   = 1'b1;
        sb.push_back('{err: 1'b0, dat: 32'hDEADBEEF, lat: 0});
        wait_resp(4, got, err, dat, lat);
        n_tests++;
        if (p_stb !== 4'b0100) begin
            n_fail++;
            $display("FAIL zw_stb: p_stb=%b want 0100", p_stb);
        end
        n_tests++;
        if ({p_adr, p_we, p_dat_c} !== {4'h3, 1'b1, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL zw_bcast: adr=%h we=%b dat=%h want 3 1 cafef00d",
                     p_adr, p_we, p_dat_c);
        end
        e = sb.pop_front();
        n_tests++;
        if (got !== 1'b1 || err !== e.err || dat !== e.dat || lat != e.lat) begin
            n_fail++;
            $display("FAIL zw_resp: got=%b err=%b dat=%h lat=%0d want err=%b dat=%h lat=%0d",
                     got, err, dat, lat, e.err, e.dat, e.lat);
        end
        m_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] adrs [3];
        logic [NP-1:0] acks [3];
        logic [DW-1:0] dats [3];
        logic got, err;
        logic [DW-1:0] dat;
        int lat;
        exp_t e;
        adrs = '{8'h0C, 8'h31, 8'h2F};
        acks = '{4'b0001, 4'b1000, 4'b0100};
        dats = '{32'hA0A0A0A0, 32'h33333333, 32'hDEADBEEF};
        for (int k = 0; k < 3; k++) begin
            step();
            m_adr = adrs[k];
            p_ack = acks[k];
            sb.push_back('{err: 1'b0, dat: dats[k], lat: 0});
            wait_resp(4, got, err, dat, lat);
            n_tests++;
            if (p_stb !== acks[k]) begin
                n_fail++;
                $display("FAIL b2b_stb[%0d]: p_stb=%b want %b", k, p_stb, acks[k]);
            end
            e = sb.pop_front();
            n_tests++;
            if (got !== 1'b1 || err !== e.err || dat !== e.dat || lat != e.lat) begin
                n_fail++;
                $display("FAIL b2b_resp[%0d]: got=%b err=%b dat=%h lat=%0d want err=%b dat=%h lat=%0d",
                         k, got, err, dat, lat, e.err, e.dat, e.lat);
            end
        end
        step();
        m_stb = 1'b0;
        p_ack = '0;
    endtask

    task automatic test_wait_lock();
        logic got, err, stb_ok;
        logic [DW-1:0] dat;
        int lat;
        exp_t e;
        step();
        m_adr = 8'h15;
        m_stb = 1'b1;
        p_ack = '0;
        sb.push_back('{err: 1'b0, dat: 32'h11111111, lat: 3});
        got    = 1'b0;
        err    = 1'b0;
        dat    = '0;
        lat    = -1;
        stb_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) m_adr = 8'h35;
            if (c == 2) p_ack = 4'b1000;
            if (c == 3) p_ack = 4'b0010;
            @(negedge clk);
            if (p_stb !== 4'b0010) stb_ok = 1'b0;
            if (m_ack || m_err) begin
                got = 1'b1;
                err = m_err;
                dat = m_dat_p;
                lat = c;
                break;
            end
            step();
        end
        n_tests++;
        if (stb_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_stb: p_stb left 0010 during wait (last %b)", p_stb);
        end
        e = sb.pop_front();
        n_tests++;
        if (got !== 1'b1 || err !== e.err || dat !== e.dat || lat != e.lat) begin
            n_fail++;
            $display("FAIL lock_resp: got=%b err=%b dat=%h lat=%0d want err=%b dat=%h lat=%0d",
                     got, err, dat, lat, e.err, e.dat, e.lat);
        end
        step();
        m_stb = 1'b0;
        p_ack = '0;
    endtask

    task automatic test_unmapped();
        logic got, err;
        logic [DW-1:0] dat;
        int lat;
        exp_t e;
        step();
        m_adr = 8'h7F;
        m_stb = 1'b1;
        p_ack = 4'b1111;
        sb.push_back('{err: 1'b1, dat: 32'h0, lat: 1});
        @(negedge clk);
        n_tests++;
        if ({p_stb, m_ack, m_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL unmap_req: p_stb=%b ack=%b err=%b want 0000 0 0",
                     p_stb, m_ack, m_err);
        end
        step();
        wait_resp(4, got, err, dat, lat);
        lat = lat + 1;
        e = sb.pop_front();
        n_tests++;
        if (got !== 1'b1 || err !== e.err || dat !== e.dat || lat != e.lat) begin
            n_fail++;
            $display("FAIL unmap_resp: got=%b err=%b dat=%h lat=%0d want err=%b dat=%h lat=%0d",
                     got, err, dat, lat, e.err, e.dat, e.lat);
        end
        step();
        m_stb = 1'b0;
        p_ack = '0;
        @(negedge clk);
        n_tests++;
        if (m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL unmap_oneshot: m_err=%b want 0", m_err);
        end
    endtask

    task automatic test_timeout();
        logic got, err, nt_bad;
        logic [NP-1:0] stb_at;
        int lat;
        exp_t e;
        step();
        m_adr = 8'h05;
        m_stb = 1'b1;
        p_ack = '0;
        sb.push_back('{err: 1'b1, dat: 32'h0, lat: 16});
        got    = 1'b0;
        err    = 1'b0;
        lat    = -1;
        stb_at = 'x;
        nt_bad = 1'b0;
        for (int c = 0; c < 105; c++) begin
            @(negedge clk);
            if (!got && (m_ack || m_err)) begin
                got    = 1'b1;
                err    = m_err && !m_ack;
                lat    = c;
                stb_at = p_stb;
            end
            if (nt_ack || nt_err) nt_bad = 1'b1;
            step();
        end
        e = sb.pop_front();
        n_tests++;
        if (got !== 1'b1 || err !== e.err || lat != e.lat) begin
            n_fail++;
            $display("FAIL tmo_resp: got=%b err=%b lat=%0d want err=%b lat=%0d",
                     got, err, lat, e.err, e.lat);
        end
        n_tests++;
        if (stb_at !== 4'b0000) begin
            n_fail++;
            $display("FAIL tmo_stb: p_stb=%b on error cycle want 0000", stb_at);
        end
        n_tests++;
        if (nt_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_disabled: TIMEOUT=0 instance responded=%b want 0", nt_bad);
        end
        m_stb = 1'b0;
    endtask

    task automatic test_ignore_abort();
        logic got, err, bad;
        logic [DW-1:0] dat;
        int lat;
        exp_t e;
        step();
        m_adr = 8'h02;
        m_stb = 1'b1;
        p_ack = 4'b1000;
        bad   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m_ack || m_err) bad = 1'b1;
            if (c < 5) step();
        end
        n_tests++;
        if (bad !== 1'b0 || p_stb !== 4'b0001) begin
            n_fail++;
            $display("FAIL ignore_ack: responded=%b p_stb=%b want 0 0001", bad, p_stb);
        end
        step();
        m_stb = 1'b0;
        p_ack = '0;
        @(negedge clk);
        n_tests++;
        if ({p_stb, m_ack, m_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort: p_stb=%b ack=%b err=%b want 0000 0 0",
                     p_stb, m_ack, m_err);
        end
        step();
        m_stb = 1'b1;
        sb.push_back('{err: 1'b1, dat: 32'h0, lat: 16});
        wait_resp(24, got, err, dat, lat);
        e = sb.pop_front();
        n_tests++;
        if (got !== 1'b1 || err !== e.err || lat != e.lat) begin
            n_fail++;
            $display("FAIL abort_restart: got=%b err=%b lat=%0d want err=%b lat=%0d",
                     got, err, lat, e.err, e.lat);
        end
        step();
        m_stb = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic got, err;
        logic [DW-1:0] dat;
        int lat;
        exp_t e;
        step();
        m_adr = 8'h15;
        m_stb = 1'b1;
        p_ack = '0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        p_ack = 4'b0010;
        #1;
        n_tests++;
        if ({p_stb, m_ack, m_err, m_dat_p} !== 38'b0) begin
            n_fail++;
            $display("FAIL rst_mid: p_stb=%b ack=%b err=%b dat=%h want all 0",
                     p_stb, m_ack, m_err, m_dat_p);
        end
        @(posedge clk);
        #3;
        p_ack = '0;
        rst_n = 1'b1;
        step();
        m_stb = 1'b0;
        step();
        m_adr = 8'h3A;
        p_ack = 4'b1000;
        m_stb = 1'b1;
        sb.push_back('{err: 1'b0, dat: 32'h33333333, lat: 0});
        wait_resp(4, got, err, dat, lat);
        n_tests++;
        if (p_stb !== 4'b1000 || p_adr !== 4'hA) begin
            n_fail++;
            $display("FAIL rst_next_stb: p_stb=%b adr=%h want 1000 a", p_stb, p_adr);
        end
        e = sb.pop_front();
        n_tests++;
        if (got !== 1'b1 || err !== e.err || dat !== e.dat || lat != e.lat) begin
            n_fail++;
            $display("FAIL rst_next_resp: got=%b err=%b dat=%h lat=%0d want err=%b dat=%h lat=%0d",
                     got, err, dat, lat, e.err, e.dat, e.lat);
        end
        step();
        m_stb = 1'b0;
        p_ack = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_back_to_back();
        test_wait_lock();
        test_unmapped();
        test_timeout();
        test_ignore_abort();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_interconnect_n.md
# wb_interconnect_n

Parametrised single-master, N-peripheral Wishbone interconnect: the next generation of the design's master-to-peripheral crossbar. Decodes the peripheral index from the upper address bits and routes strobe, data and acknowledge for that peripheral only. Locks the selection for the whole transaction. Adds bus-error responses for unmapped addresses and a per-transaction acknowledge timeout. Sits between the MCU-side master port and the peripheral bank.

## Interface
- NPERI, 4: number of peripherals, 1..16.
- PERI_ADR_WIDTH, 4: address bits forwarded to peripherals (low bits of m_adr).
- ADR_WIDTH, 8: master address width; index field is m_adr[ADR_WIDTH-1:PERI_ADR_WIDTH].
- DAT_WIDTH, 32: data width.
- TIMEOUT, 16: cycles in BUSY without ack before m_err; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_stb  in  1  master strobe/cycle request.
- m_we  in  1  master write enable.
- m_adr  in  ADR_WIDTH  master address.
- m_dat_c  in  DAT_WIDTH  master write data.
- m_dat_p  out  DAT_WIDTH  read data to master.
- m_ack  out  1  transaction completed normally.
- m_err  out  1  transaction terminated with error (unmapped or timeout).
- p_stb  out  NPERI  one-hot peripheral strobes.
- p_we  out  1  broadcast m_we.
- p_adr  out  PERI_ADR_WIDTH  broadcast m_adr[PERI_ADR_WIDTH-1:0].
- p_dat_c  out  DAT_WIDTH  broadcast m_dat_c.
- p_dat_p  in  NPERI*DAT_WIDTH  peripheral read data; peripheral i at slice i.
- p_ack  in  NPERI  peripheral acknowledges.

## Operation
- State: IDLE, BUSY, ERR (2-bit register); registers sel_q (index width), tmo_cnt (clog2(TIMEOUT+1) bits).
- idx = m_adr[ADR_WIDTH-1:PERI_ADR_WIDTH]; valid = idx < NPERI.
- sel = idx in IDLE, sel_q in BUSY.
- p_stb[sel] = m_stb in IDLE with valid and in BUSY; all other bits 0; p_stb = 0 in ERR.
- m_ack = p_ack[sel] when p_stb[sel] is high, else 0; acks from unselected peripherals are ignored.
- m_dat_p = slice sel of p_dat_p while m_ack is high, else 0.
- IDLE:
  - m_stb & valid & p_ack[idx]: zero-wait completion, stay IDLE.
  - m_stb & valid & !p_ack[idx]: sel_q<=idx, tmo_cnt<=1, go BUSY.
  - m_stb & !valid: go ERR.
- BUSY:
  - p_ack[sel_q]: m_ack=1, go IDLE.
  - m_stb low (master abort): go IDLE, no ack/err.
  - TIMEOUT!=0 & tmo_cnt==TIMEOUT: m_err=1 this cycle, p_stb forced 0 this cycle, go IDLE. Ack wins if it arrives on the same cycle.
  - Otherwise tmo_cnt+1.
- ERR: m_err=1 for exactly one cycle, go IDLE.
- m_err and m_ack are never high in the same cycle.
- Master holds m_stb, m_adr, m_we and m_dat_c stable until ack/err. If m_stb is still high in IDLE after completion, that cycle starts a new transaction.
- Address changes during BUSY do not change sel.

## Timing
- Reset (rst_n low, async): state=IDLE, sel_q=0, tmo_cnt=0. Consequently p_stb=0, m_ack=0, m_err=0, m_dat_p=0.
- Reset asserted mid-BUSY: strobe drops immediately and the transaction is abandoned without ack.
- Combinational paths: m_stb/m_adr to p_stb; p_ack to m_ack; p_dat_p to m_dat_p. No registered latency when a peripheral acks in the request cycle.
- Ack arriving N cycles after the request: m_ack in that same cycle, total N+1 cycles of stb.
- Unmapped access: m_err one cycle after the request (latency 1).
- Timeout: m_err in the cycle where the strobe has been high for TIMEOUT+1 cycles.

## Test plan
- NPERI=4, m_adr=0x23, peripheral 2 acks in the same cycle with p_dat_p slice 2 = 0xDEADBEEF. Required: p_stb=4'b0100, p_adr=0x3, m_ack=1 that cycle, m_dat_p=0xDEADBEEF, state stays IDLE.
- m_adr=0x15, peripheral 1 acks after 3 wait cycles; m_adr changed to 0x35 during the wait. Required: p_stb stays 4'b0010 throughout, m_ack on the 4th cycle, no m_err.
- m_adr=0x7F (idx 7 ≥ 4). Required: p_stb=0, m_err=1 exactly on the next cycle, m_ack=0.
- TIMEOUT=16, peripheral 0 never acks. Required: m_err=1 on the 17th strobe cycle, p_stb[0]=0 that cycle, back to IDLE. Repeat with TIMEOUT=0: no m_err after 100 cycles.
- Peripheral 3 acks while peripheral 0 is selected. Required: m_ack stays 0. Then m_stb drops mid-BUSY: state returns to IDLE, tmo_cnt cleared.
- rst_n pulsed low for 1 cycle mid-BUSY (asynchronous, not clock-aligned). Required: p_stb, m_ack and m_err go 0 immediately, and the next request decodes normally.
